// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle between a requesting sequencer and the serial add/subtract controller.
// The master drives the request side; the controller (slave) returns status and result.
interface serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Multi-precision add/subtract built on one shared 4-bit ripple-carry adder,
// processing one nibble per clock, LSB first, with the carry held between cycles.
//
// state | meaning
// IDLE  | waiting for start; result/cout/overflow hold the last answer
// RUN   | adding nibble idx, carry chained through the carry register
// DONE  | one-cycle done pulse, then back to IDLE
module serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic           clock,
    input logic           reset,
    serial_add_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   result_q;
    logic           carry;
    logic [IW-1:0]  idx;
    logic           busy_q;
    logic           done_q;
    logic           cout_q;
    logic           overflow_q;

    logic [3:0]     nib_a;
    logic [3:0]     nib_b;
    logic [3:0]     sum;
    logic           add_cout;

    assign nib_a = op_a[idx*4 +: 4];
    assign nib_b = op_b[idx*4 +: 4];

    // The shared 4-bit ripple-carry adder: four chained full adders.
    always_comb begin
        logic c;
        c   = carry;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = nib_a[i] ^ nib_b[i] ^ c;
            c      = (nib_a[i] & nib_b[i]) | (c & (nib_a[i] ^ nib_b[i]));
        end
        add_cout = c;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            result_q   <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Subtraction is A + ~B + 1; cin is ignored in that mode.
                        op_a     <= bus.a;
                        op_b     <= bus.sub ? ~bus.b : bus.b;
                        carry    <= bus.sub ? 1'b1 : bus.cin;
                        idx      <= '0;
                        result_q <= '0;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result_q[idx*4 +: 4] <= sum;
                    carry                <= add_cout;
                    if (idx == IW'(NIBBLES - 1)) begin
                        cout_q     <= add_cout;
                        overflow_q <= (op_a[W-1] == op_b[W-1]) && (sum[3] != op_a[W-1]);
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (NIBBLES=4): hand-computed sums, flag edges,
// held-start throughput and mid-operation reset.
module tb_serial_add_ctrl;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    serial_add_ctrl_if #(.NIBBLES(4)) sif ();

    serial_add_ctrl #(.NIBBLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then check busy for 4 cycles, the done cycle and the one after.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin,
                          input logic [15:0] exp_res, input logic exp_cout, input logic exp_ovf);
        sif.a     = a;
        sif.b     = b;
        sif.sub   = sub;
        sif.cin   = cin;
        sif.start = 1'b1;
        @(negedge clock);
        sif.start = 1'b0;
        sif.a     = ~a;
        sif.b     = ~b;
        sif.sub   = ~sub;
        for (int i = 0; i < 4; i++) begin
            check({tag, " busy"}, {31'd0, sif.busy}, 32'd1);
            check({tag, " done_early"}, {31'd0, sif.done}, 32'd0);
            @(negedge clock);
        end
        check({tag, " done"}, {31'd0, sif.done}, 32'd1);
        check({tag, " busy_at_done"}, {31'd0, sif.busy}, 32'd0);
        check({tag, " result"}, {16'd0, sif.result}, {16'd0, exp_res});
        check({tag, " cout"}, {31'd0, sif.cout}, {31'd0, exp_cout});
        check({tag, " overflow"}, {31'd0, sif.overflow}, {31'd0, exp_ovf});
        @(negedge clock);
        check({tag, " done_single"}, {31'd0, sif.done}, 32'd0);
        check({tag, " result_hold"}, {16'd0, sif.result}, {16'd0, exp_res});
    endtask

    int done_cnt;

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        sif.start = 1'b0;
        sif.sub   = 1'b0;
        sif.cin   = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        repeat (2) @(negedge clock);
        check("rst busy", {31'd0, sif.busy}, 32'd0);
        check("rst done", {31'd0, sif.done}, 32'd0);
        check("rst result", {16'd0, sif.result}, 32'd0);
        check("rst cout", {31'd0, sif.cout}, 32'd0);
        check("rst ovf", {31'd0, sif.overflow}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_op("add1234",   16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("addwrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("addcin",    16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_borrow",16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_plain", 16'h5555, 16'h1111, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b0);
        run_op("addcin2",   16'h00FF, 16'h0F01, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0);

        // Start held high; operands change right after the accepting edge.
        sif.a     = 16'h1000;
        sif.b     = 16'h0001;
        sif.sub   = 1'b0;
        sif.cin   = 1'b0;
        sif.start = 1'b1;
        done_cnt  = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (k == 1) begin
                sif.a = 16'h2000;
                sif.b = 16'h0002;
            end
            check("held busy_and_done", {31'd0, sif.busy & sif.done}, 32'd0);
            if (sif.done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    check("held cycle1", k, 5);
                    check("held res1", {16'd0, sif.result}, 32'h1001);
                end else begin
                    check("held cycle2", k, 11);
                    check("held res2", {16'd0, sif.result}, 32'h2002);
                end
            end
        end
        sif.start = 1'b0;
        check("held done_count", done_cnt, 2);
        repeat (2) @(negedge clock);

        // Leave cout=1 and overflow=1 behind so the reset clearing is visible.
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // Reset sampled at E2 of an operation.
        sif.a     = 16'h1234;
        sif.b     = 16'h0FFF;
        sif.sub   = 1'b0;
        sif.cin   = 1'b0;
        sif.start = 1'b1;
        @(negedge clock);
        sif.start = 1'b0;
        @(negedge clock);
        check("mid partial", {16'd0, sif.result}, 32'h0003);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid busy", {31'd0, sif.busy}, 32'd0);
        check("mid done", {31'd0, sif.done}, 32'd0);
        check("mid result", {16'd0, sif.result}, 32'd0);
        check("mid cout", {31'd0, sif.cout}, 32'd0);
        check("mid ovf", {31'd0, sif.overflow}, 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (sif.done) done_cnt++;
        end
        check("mid no_done", done_cnt, 0);
        run_op("after_rst", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
